// File: rtl/channel_arbiter_if.sv
// Handshake bundle between channel_arbiter, its producers, the channel
// multiplexer and the downstream consumer.
interface channel_arbiter_if #(
  parameter int N  = 5,
  parameter int M  = 4,
  parameter int SW = 3
);
  logic [N-1:0]  req;
  logic [M-1:0]  mux_out;
  logic [SW-1:0] select;
  logic [N-1:0]  grant;
  logic          out_valid;
  logic [M-1:0]  out_data;
  logic          out_ready;

  // The arbiter side drives select/grant and the captured word.
  modport master (
    input  req, mux_out, out_ready,
    output select, grant, out_valid, out_data
  );

  modport slave (
    output req, mux_out, out_ready,
    input  select, grant, out_valid, out_data
  );
endinterface

// File: rtl/channel_arbiter.sv
// Round-robin arbiter driving a channel multiplexer select, capturing its
// output one cycle later and presenting it through a valid/ready handshake.
module channel_arbiter #(
  parameter int N  = 5,
  parameter int M  = 4,
  parameter int SW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  channel_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  state_t        state, state_d;
  logic [SW-1:0] last, last_d;
  logic [SW-1:0] select_d;
  logic [N-1:0]  grant_d;
  logic          out_valid_d;
  logic [M-1:0]  out_data_d;
  logic [SW-1:0] pick;
  logic [SW-1:0] idx;
  logic          found;

  // Search starts just after the last served channel and wraps N-1 -> 0
  // explicitly, so indices >= N are never produced for non power-of-two N.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    pick  = last;
    found = 1'b0;
    idx   = last;
    for (int k = 0; k < N; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state;
    last_d      = last;
    select_d    = bus.select;
    grant_d     = '0;
    out_valid_d = bus.out_valid;
    out_data_d  = bus.out_data;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          select_d = pick;
          state_d  = SELECT;
        end
      end
      SELECT: begin
        // req is deliberately not re-checked: the picked channel is captured.
        out_data_d  = bus.mux_out;
        out_valid_d = 1'b1;
        grant_d     = N'(1) << bus.select;
        last_d      = bus.select;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_valid && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (|bus.req) begin
            select_d = pick;
            state_d  = SELECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= LAST_IDX;
      bus.select    <= '0;
      bus.grant     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      state         <= state_d;
      last          <= last_d;
      bus.select    <= select_d;
      bus.grant     <= grant_d;
      bus.out_valid <= out_valid_d;
      bus.out_data  <= out_data_d;
    end
  end

endmodule
